// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC vectoring engine:
// atan lookup in integer degrees and the sequencer state encoding.
package cordic_pkg;

  localparam int N_ITER_MAX  = 6;
  localparam int ANGLE_W_DEF = 16;

  typedef logic signed [ANGLE_W_DEF-1:0] angle_t;

  // atan(2^-k) rounded to whole degrees
  localparam angle_t ATAN_TABLE [N_ITER_MAX] = '{
    16'sd45, 16'sd27, 16'sd14, 16'sd7, 16'sd4, 16'sd2
  };

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

endpackage

// File: rtl/cordic_iter_stage.sv
// One combinational CORDIC vectoring micro-rotation: drives Q toward zero and
// accumulates the rotated angle. Both shifts use the incoming (old) I/Q.
module cordic_iter_stage
  import cordic_pkg::*;
#(
  parameter int INT_W   = 10,
  parameter int ANGLE_W = 16
) (
  input  logic [INT_W-1:0]   inph,
  input  logic [INT_W-1:0]   quad,
  input  logic [ANGLE_W-1:0] angle,
  input  logic [2:0]         k,
  output logic [INT_W-1:0]   inph_next,
  output logic [INT_W-1:0]   quad_next,
  output logic [ANGLE_W-1:0] angle_next
);

  logic signed [INT_W-1:0]   inph_s;
  logic signed [INT_W-1:0]   quad_s;
  logic signed [INT_W-1:0]   inph_sh;
  logic signed [INT_W-1:0]   quad_sh;
  logic signed [ANGLE_W-1:0] angle_s;
  logic signed [ANGLE_W-1:0] atan_k;

  always_comb begin
    inph_s  = $signed(inph);
    quad_s  = $signed(quad);
    angle_s = $signed(angle);
    inph_sh = inph_s >>> k;
    quad_sh = quad_s >>> k;
    atan_k  = (int'(k) < N_ITER_MAX) ? ANGLE_W'(ATAN_TABLE[k]) : '0;
    if (quad_s < 0) begin
      inph_next  = inph_s - quad_sh;
      quad_next  = quad_s + inph_sh;
      angle_next = angle_s - atan_k;
    end else begin
      inph_next  = inph_s + quad_sh;
      quad_next  = quad_s - inph_sh;
      angle_next = angle_s + atan_k;
    end
  end

endmodule

// File: rtl/cordic_vector_sequencer.sv
// Iterative CORDIC vectoring engine: quadrant pre-rotation on accept, then up
// to N_ITER micro-rotations on a single shared stage; phase out in degrees.
module cordic_vector_sequencer
  import cordic_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int FRAC    = 4,
  parameter int N_ITER  = 6,
  parameter int ANGLE_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_I,
  input  logic [DATA_W-1:0]  i_Q,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [ANGLE_W-1:0] o_angle
);

  localparam int INT_W = DATA_W + FRAC + 2;

  state_t                    state;
  logic signed [INT_W-1:0]   r_i;
  logic signed [INT_W-1:0]   r_q;
  logic signed [ANGLE_W-1:0] r_z;
  logic [2:0]                r_k;

  logic signed [INT_W-1:0]   x_ext;
  logic signed [INT_W-1:0]   y_ext;
  logic [INT_W-1:0]          i_nx;
  logic [INT_W-1:0]          q_nx;
  logic [ANGLE_W-1:0]        z_nx;

  always_comb begin
    x_ext = {{(INT_W-DATA_W){i_I[DATA_W-1]}}, i_I} <<< FRAC;
    y_ext = {{(INT_W-DATA_W){i_Q[DATA_W-1]}}, i_Q} <<< FRAC;
  end

  cordic_iter_stage #(
    .INT_W   (INT_W),
    .ANGLE_W (ANGLE_W)
  ) u_stage (
    .inph       (r_i),
    .quad       (r_q),
    .angle      (r_z),
    .k          (r_k),
    .inph_next  (i_nx),
    .quad_next  (q_nx),
    .angle_next (z_nx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
      o_angle <= '0;
      r_i     <= '0;
      r_q     <= '0;
      r_z     <= '0;
      r_k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            o_ready <= 1'b0;
            r_k     <= '0;
            state   <= ITER;
            // fold left half-plane inputs into the right half-plane by +/-90
            if (!x_ext[INT_W-1]) begin
              r_i <= x_ext;
              r_q <= y_ext;
              r_z <= '0;
            end else if (!y_ext[INT_W-1]) begin
              r_i <= y_ext;
              r_q <= -x_ext;
              r_z <= ANGLE_W'(90);
            end else begin
              r_i <= -y_ext;
              r_q <= x_ext;
              r_z <= ANGLE_W'(-90);
            end
          end
        end
        ITER: begin
          if (r_q == '0) begin
            state   <= DONE;
            o_valid <= 1'b1;
            o_angle <= r_z;
          end else begin
            r_i <= i_nx;
            r_q <= q_nx;
            r_z <= z_nx;
            if (r_k == 3'(N_ITER - 1)) begin
              state   <= DONE;
              o_valid <= 1'b1;
              o_angle <= z_nx;
            end else begin
              r_k <= r_k + 3'd1;
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector_sequencer.sv
// Randomized self-checking bench for cordic_vector_sequencer against a
// plain-arithmetic CORDIC vectoring model (angle and accept-to-valid latency).
module tb_cordic_vector_sequencer;

  logic        clock;
  logic        reset;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_I;
  logic [3:0]  i_Q;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_angle;

  int errors = 0;
  int checks = 0;

  cordic_vector_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_I     (i_I),
    .i_Q     (i_Q),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_angle (o_angle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Vectoring reference: rotate (x,y) onto the positive x axis, summing angles.
  function automatic void ref_model(input int si, input int sq, output int ang, output int lat);
    int atan_deg [6] = '{45, 27, 14, 7, 4, 2};
    int x, y, z, t, xn, yn;
    x = si * 16;
    y = sq * 16;
    z = 0;
    if (x < 0) begin
      t = x;
      if (y >= 0) begin x = y;  y = -t; z = 90;  end
      else        begin x = -y; y = t;  z = -90; end
    end
    lat = 7;
    for (int k = 0; k < 6; k++) begin
      if (y == 0) begin
        lat = k + 2;
        break;
      end
      if (y > 0) begin
        xn = x + (y >>> k); yn = y - (x >>> k); z = z + atan_deg[k];
      end else begin
        xn = x - (y >>> k); yn = y + (x >>> k); z = z - atan_deg[k];
      end
      x = xn;
      y = yn;
    end
    ang = z;
  endfunction

  task automatic run_sample(input int si, input int sq, input int stall);
    int exp_ang, exp_lat, lat, waited;
    bit got;
    ref_model(si, sq, exp_ang, exp_lat);
    @(negedge clock);
    waited = 0;
    while (!o_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!o_ready) check_val("ready_timeout", 0, 1);
    i_I     = 4'(si);
    i_Q     = 4'(sq);
    i_valid = 1'b1;
    i_ready = (stall == 0);
    @(posedge clock);
    @(negedge clock);
    i_valid = 1'b0;
    lat = 1;
    got = o_valid;
    while (!got && lat < 20) begin
      check_val("busy_ready", int'(o_ready), 0);
      @(posedge clock);
      lat++;
      @(negedge clock);
      got = o_valid;
    end
    check_val("valid_seen", int'(got), 1);
    check_val("latency", lat, exp_lat);
    check_val("angle", int'($signed(o_angle)), exp_ang);
    for (int s = 0; s < stall; s++) begin
      i_I     = 4'($urandom_range(15));
      i_Q     = 4'($urandom_range(15));
      i_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_val("hold_valid", int'(o_valid), 1);
      check_val("hold_ready", int'(o_ready), 0);
      check_val("hold_angle", int'($signed(o_angle)), exp_ang);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_val("post_valid", int'(o_valid), 0);
    check_val("post_ready", int'(o_ready), 1);
    $display("sample I=%0d Q=%0d stall=%0d -> angle=%0d (exp %0d) lat=%0d (exp %0d)",
             si, sq, stall, $signed(o_angle), exp_ang, lat, exp_lat);
    i_ready = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_I     = '0;
    i_Q     = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_val("rst_valid", int'(o_valid), 0);
    check_val("rst_ready", int'(o_ready), 1);
    check_val("rst_angle", int'($signed(o_angle)), 0);

    run_sample(4, 0, 0);
    run_sample(4, 4, 0);
    run_sample(0, -4, 0);
    run_sample(-4, 0, 0);
    run_sample(4, 4, 5);

    // Reset in the middle of a full run (k=3) must discard the sample.
    @(negedge clock);
    i_I = 4'd0; i_Q = 4'hC; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    i_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_val("midrst_valid", int'(o_valid), 0);
    check_val("midrst_ready", int'(o_ready), 1);
    check_val("midrst_angle", int'($signed(o_angle)), 0);
    $display("mid-run reset -> valid=%0d ready=%0d angle=%0d", o_valid, o_ready, $signed(o_angle));
    i_ready = 1'b0;
    run_sample(4, 4, 0);

    run_sample(-8, -8, 1);
    run_sample(7, -8, 0);
    run_sample(-8, 7, 2);
    for (int n = 0; n < 40; n++) begin
      run_sample(int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                 int'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
